// File: rtl/traffic_control_multi.sv
// Highway plus NUM_SIDE side-road signal controller.
// Sticky side requests are served round-robin, one per highway green.
module traffic_control_multi #(
    parameter int NUM_SIDE       = 2,
    parameter int MIN_GREEN      = 4,
    parameter int Y2R_CYCLES     = 3,
    parameter int R2G_CYCLES     = 2,
    parameter int MAX_SIDE_GREEN = 8,
    localparam int SW = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [NUM_SIDE-1:0]   x,
    output logic [1:0]            hwy,
    output logic [2*NUM_SIDE-1:0] side,
    output logic [SW-1:0]         sel,
    output logic [2:0]            phase
);

    localparam int M1    = (MIN_GREEN > Y2R_CYCLES) ? MIN_GREEN : Y2R_CYCLES;
    localparam int M2    = (M1 > R2G_CYCLES) ? M1 : R2G_CYCLES;
    localparam int MAX_P = (M2 > MAX_SIDE_GREEN) ? M2 : MAX_SIDE_GREEN;
    localparam int TW    = $clog2(MAX_P + 1);

    localparam logic [TW-1:0] T_MG  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_Y2R = TW'(Y2R_CYCLES - 1);
    localparam logic [TW-1:0] T_R2G = TW'(R2G_CYCLES - 1);
    localparam logic [TW-1:0] T_MSG = TW'(MAX_SIDE_GREEN - 1);

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_SIDE-1:0] req_q, req_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [NUM_SIDE-1:0] pending;
    logic [SW-1:0]       rr_sel;

    assign pending = req_q | x;

    // First pending side after the one last served, wrapping around.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        int            n;
        rr_sel = sel_q;
        found  = 1'b0;
        idx    = '0;
        n      = 0;
        for (int k = 1; k <= NUM_SIDE; k++) begin
            n   = (int'(sel_q) + k) % NUM_SIDE;
            idx = SW'(n);
            if (!found && pending[idx]) begin
                found  = 1'b1;
                rr_sel = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q | x;
        sel_d   = sel_q;
        timer_d = timer_q + 1'b1;
        case (state_q)
            HG: begin
                if (timer_q == '1) timer_d = timer_q;
                if (timer_q >= T_MG && |pending) begin
                    state_d = HY;
                    sel_d   = rr_sel;
                end
            end
            HY:  if (timer_q == T_Y2R) state_d = AR1;
            AR1: begin
                if (timer_q == T_R2G) begin
                    state_d       = SG;
                    req_d[sel_q]  = 1'b0;
                end
            end
            SG: begin
                req_d[sel_q] = req_q[sel_q];
                if (!x[sel_q] || timer_q == T_MSG) state_d = SY;
            end
            SY:  if (timer_q == T_Y2R) state_d = AR2;
            AR2: if (timer_q == T_R2G) state_d = HG;
            default: state_d = HG;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= HG;
            timer_q <= '0;
            req_q   <= '0;
            sel_q   <= SW'(NUM_SIDE - 1);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        logic [1:0] s_lamp;
        hwy    = RED;
        s_lamp = RED;
        side   = '0;
        case (state_q)
            HG:      hwy    = GREEN;
            HY:      hwy    = YELLOW;
            SG:      s_lamp = GREEN;
            SY:      s_lamp = YELLOW;
            default: hwy    = RED;
        endcase
        for (int i = 0; i < NUM_SIDE; i++) begin
            if (SW'(i) == sel_q) side[2*i +: 2] = s_lamp;
        end
    end

    assign sel   = sel_q;
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_control_multi.sv
// Bench for traffic_control_multi: directed scenarios plus random
// sensor traffic against a phase/age reference model.
module tb_traffic_control_multi;

    localparam int NS  = 2;
    localparam int MG  = 4;
    localparam int Y2R = 3;
    localparam int R2G = 2;
    localparam int MSG = 8;

    logic            clock = 1'b0;
    logic            clear_n;
    logic [NS-1:0]   x;
    logic [1:0]      hwy;
    logic [2*NS-1:0] side;
    logic [0:0]      sel;
    logic [2:0]      phase;

    int checks = 0;
    int errors = 0;

    // Model: phase id, cycles spent in phase (1 = first), request mask, served side.
    int m_ph;
    int m_age;
    int m_req;
    int m_sel;

    always #5 clock = ~clock;

    traffic_control_multi #(
        .NUM_SIDE(NS),
        .MIN_GREEN(MG),
        .Y2R_CYCLES(Y2R),
        .R2G_CYCLES(R2G),
        .MAX_SIDE_GREEN(MSG)
    ) dut (
        .clock(clock),
        .clear_n(clear_n),
        .x(x),
        .hwy(hwy),
        .side(side),
        .sel(sel),
        .phase(phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph  = 0;
        m_age = 1;
        m_req = 0;
        m_sel = NS - 1;
    endtask

    task automatic model_step(input logic [NS-1:0] xv);
        int  pend;
        int  nph;
        int  nsel;
        int  idx;
        bit  found;
        pend  = m_req | int'(xv);
        nph   = m_ph;
        nsel  = m_sel;
        found = 0;
        case (m_ph)
            0: if (m_age >= MG && pend != 0) begin
                nph = 1;
                for (int k = 1; k <= NS; k++) begin
                    idx = (m_sel + k) % NS;
                    if (!found && ((pend >> idx) & 1) == 1) begin
                        found = 1;
                        nsel  = idx;
                    end
                end
            end
            1: if (m_age == Y2R) nph = 2;
            2: if (m_age == R2G) nph = 3;
            3: if (xv[m_sel] == 1'b0 || m_age == MSG) nph = 4;
            4: if (m_age == Y2R) nph = 5;
            5: if (m_age == R2G) nph = 0;
            default: nph = 0;
        endcase
        for (int i = 0; i < NS; i++) begin
            if (xv[i] && !(m_ph == 3 && m_sel == i)) m_req |= (1 << i);
        end
        if (m_ph == 2 && nph == 3) m_req &= ~(1 << m_sel);
        m_age = (nph != m_ph) ? 1 : m_age + 1;
        m_ph  = nph;
        m_sel = nsel;
    endtask

    task automatic compare_model();
        int eh;
        int es;
        int sl;
        eh = (m_ph == 0) ? 2 : (m_ph == 1) ? 1 : 0;
        sl = (m_ph == 3) ? 2 : (m_ph == 4) ? 1 : 0;
        es = sl << (2 * m_sel);
        chk("hwy", hwy, eh);
        chk("side", side, es);
        chk("sel", sel, m_sel);
        chk("phase", phase, m_ph);
    endtask

    task automatic tick();
        model_step(x);
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n;
        n = 0;
        while (phase !== p[2:0] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("reach_phase%0d", p), phase, p);
    endtask

    task automatic count_phase(input int p, output int n);
        n = 0;
        while (phase === p[2:0] && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        chk("rst_hwy", hwy, 2);
        chk("rst_side", side, 0);
        chk("rst_phase", phase, 0);
        chk("rst_sel", sel, NS - 1);
        model_reset();
        @(posedge clock);
        #1;
        clear_n = 1'b1;
    endtask

    initial begin
        int ph_at[1:12];
        int n;
        clear_n = 1'b1;
        x       = '0;
        model_reset();

        // Idle highway, timer runs well past saturation.
        do_reset();
        repeat (50) tick();
        chk("idle_phase", phase, 0);
        x = 2'b01;
        tick();
        chk("sat_to_hy", phase, 1);

        // Default timing from reset with x[0] high.
        x = 2'b01;
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            tick();
            ph_at[e] = int'(phase);
        end
        chk("e3_hg", ph_at[3], 0);
        chk("e4_hy", ph_at[4], 1);
        chk("e6_hy", ph_at[6], 1);
        chk("e7_ar1", ph_at[7], 2);
        chk("e8_ar1", ph_at[8], 2);
        chk("e9_sg", ph_at[9], 3);
        chk("e9_sel", sel, 0);
        chk("e9_side", side, 4'b0010);
        tick();
        tick();
        x = 2'b00;
        tick();
        chk("e12_sy", phase, 4);
        wait_phase(0, 20);

        // One-cycle pulse on side 1 at HG timer 0.
        x = 2'b10;
        tick();
        x = 2'b00;
        n = 1;
        while (phase !== 3'd1 && n < 20) begin
            tick();
            n++;
        end
        chk("pulse_hy_edge", n, 4);
        wait_phase(3, 10);
        chk("pulse_sel", sel, 1);
        count_phase(3, n);
        chk("pulse_sg_len", n, 1);

        // Both sensors held: alternate with full-length side greens.
        x = 2'b11;
        wait_phase(0, 20);
        for (int s = 0; s < 4; s++) begin
            wait_phase(3, 30);
            chk($sformatf("rr_sel%0d", s), sel, s % 2);
            count_phase(3, n);
            chk($sformatf("rr_sg_len%0d", s), n, MSG);
            wait_phase(0, 20);
            count_phase(0, n);
            chk($sformatf("rr_hg_len%0d", s), n, MG);
        end

        // Reset in the middle of side yellow.
        wait_phase(4, 40);
        tick();
        x = 2'b00;
        do_reset();
        repeat (10) tick();
        chk("post_rst_idle", phase, 0);
        x = 2'b11;
        wait_phase(3, 20);
        chk("post_rst_sel", sel, 0);

        // Random sensor traffic.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 3) == 0) x = NS'($urandom_range(0, (1 << NS) - 1));
            if (it == 700) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
